// File: rtl/mul.sv
// Sequential unsigned 9x9 shift-and-add multiplier; optional MUL_EARLY_EXIT_EN ends the run once the multiplier is exhausted.
// Latency 9 edges after reset release (1 + top set bit of B with early exit); no backpressure, res/done hold until next reset.
module mul (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  A,
  input  logic [8:0]  B,
  output logic [17:0] res,
  output logic        done
);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [17:0] mcand, mcand_nxt;
  logic [8:0]  mplier, mplier_nxt;
  logic [17:0] acc, acc_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [17:0] res_nxt;
  logic        done_nxt;
  logic [17:0] sum;
  logic        last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD;
      mcand  <= {9'b0, A};
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
      res    <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      res    <= res_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    res_nxt    = res;
    done_nxt   = done;
    sum        = mplier[0] ? (acc + mcand) : acc;
`ifdef MUL_EARLY_EXIT_EN
    last       = (cnt == 4'd8) || (mplier[8:1] == 8'd0);
`else
    last       = (cnt == 4'd8);
`endif

    case (state)
      // LOAD's exit edge is already step 0, so both states share the step datapath
      LOAD, RUN: begin
        acc_nxt    = sum;
        mcand_nxt  = {mcand[16:0], 1'b0};
        mplier_nxt = {1'b0, mplier[8:1]};
        cnt_nxt    = cnt + 4'd1;
        state_nxt  = RUN;
        if (last) begin
          res_nxt   = sum;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mul.sv
module tb_mul;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  A, B;
  logic [17:0] res;
  logic        done;

  int tests = 0;
  int fails = 0;

  int exp_q[$];
  int lat_q[$];

  bit          rst_seen = 1'b0;
  int          cyc = 0;
  logic        done_q = 1'b0;
  logic [17:0] held = '0;

  mul dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .res   (res),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_seen <= reset;
    cyc      <= reset ? 0 : cyc + 1;
  end

  function automatic int exp_lat(input logic [8:0] b);
    int l;
    l = 9;
`ifdef MUL_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < 9; i++)
      if (b[i]) l = i + 1;
`endif
    return l;
  endfunction

  // Monitor: compares against the scoreboard whenever done rises; checks zero/hold otherwise
  always @(negedge clk) begin
    if (rst_seen) begin
      tests++;
      if (done !== 1'b0 || res !== 18'd0) begin
        fails++;
        $display("FAIL rst_state: res=%0d done=%b, required res=0 done=0", res, done);
      end
    end else if (done !== 1'b1) begin
      tests++;
      if (res !== 18'd0 || done !== 1'b0) begin
        fails++;
        $display("FAIL partial: res=%0d done=%b before completion, required res=0 done=0", res, done);
      end
    end else if (!done_q) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: res=%0d at cycle %0d with no operation pending", res, cyc);
      end else begin
        int e, l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        if (int'(res) != e || cyc != l) begin
          fails++;
          $display("FAIL product: res=%0d after %0d cycles, required %0d after %0d cycles", res, cyc, e, l);
        end
      end
      held = res;
    end else begin
      tests++;
      if (res !== held) begin
        fails++;
        $display("FAIL hold: res=%0d, required held value %0d", res, held);
      end
    end
    done_q = done;
  end

  task automatic run_op(input logic [8:0] a, input logic [8:0] b, input int hold, input bit tog);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      reset = 1'b1;
      if (i == hold - 1) begin
        A = a;
        B = b;
      end else begin
        A = 9'($urandom);
        B = 9'($urandom);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(int'(a) * int'(b));
    lat_q.push_back(exp_lat(b));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tog) begin
        A = 9'($urandom);
        B = 9'($urandom);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL timeout: %0d result(s) still pending for A=%0d B=%0d, required 0", exp_q.size(), a, b);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic abort_op(input logic [8:0] a, input logic [8:0] b, input int run_cycles);
    @(negedge clk);
    reset = 1'b1;
    A = a;
    B = b;
    @(negedge clk);
    reset = 1'b0;
    repeat (run_cycles) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);

    run_op(9'd25, 9'd20, 1, 1'b0);
    run_op(9'd24, 9'd26, 1, 1'b0);
    run_op(9'd6, 9'd23, 1, 1'b0);
    run_op(9'd43, 9'd33, 1, 1'b0);
    run_op(9'd341, 9'd345, 1, 1'b0);
    run_op(9'd511, 9'd511, 1, 1'b1);
    abort_op(9'd200, 9'd301, 4);
    run_op(9'd3, 9'd5, 1, 1'b0);
    run_op(9'd511, 9'd0, 1, 1'b0);
    run_op(9'd0, 9'd511, 1, 1'b1);
    run_op(9'd1, 9'd1, 1, 1'b0);
    run_op(9'd77, 9'd256, 3, 1'b1);

    for (int n = 0; n < 24; n++)
      run_op(9'($urandom), 9'($urandom), 1 + int'($urandom_range(0, 2)), 1'($urandom));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
